// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: controller
// state encoding and the default geometry.
package icache_pkg;

    localparam int unsigned INDEX_BITS_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data line store: one combinational read port, one write port,
// single-cycle bulk invalidate (which wins over a same-cycle write).
module icache_store #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_W      = 24
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  clr_all_in,
    input  logic [INDEX_BITS-1:0] rd_idx_in,
    output logic                  rd_valid_out,
    output logic [TAG_W-1:0]      rd_tag_out,
    output logic [31:0]           rd_data_out,
    input  logic                  we_in,
    input  logic [INDEX_BITS-1:0] wr_idx_in,
    input  logic [TAG_W-1:0]      wr_tag_in,
    input  logic [31:0]           wr_data_in
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    always_comb begin
        valid_d = valid_q;
        if (clr_all_in) begin
            valid_d = '0;
        end else if (we_in) begin
            valid_d[wr_idx_in] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data need no reset; the valid bit guards them.
    always_ff @(posedge clk_in) begin
        if (we_in) begin
            tag_mem[wr_idx_in]  <= wr_tag_in;
            data_mem[wr_idx_in] <= wr_data_in;
        end
    end

    assign rd_valid_out = valid_q[rd_idx_in];
    assign rd_tag_out   = tag_mem[rd_idx_in];
    assign rd_data_out  = data_mem[rd_idx_in];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache with a single outstanding
// refill; hits answer the cycle after acceptance, rdy_in low freezes everything.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        fetch_valid_in,
    input  logic [31:0] fetch_pc_in,
    output logic        fetch_ready_out,
    output logic        inst_valid_out,
    output logic [31:0] inst_out,
    output logic        icache_in,
    output logic [31:0] icache_address_in,
    input  logic        icache_received,
    input  logic        icache_task_out,
    input  logic [31:0] value_load
);
    localparam int TAG_W = 32 - INDEX_BITS - 2;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        inst_vld_q, inst_vld_d;
    logic [31:0] inst_q, inst_d;
    logic        no_install_q, no_install_d;

    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [31:0]           rd_data;
    logic                  hit;
    logic                  we;
    logic                  clr_all;
    logic [1:0]            unused_pc_bits;

    assign unused_pc_bits  = fetch_pc_in[1:0];
    assign fetch_ready_out = (state_q == ST_IDLE) && !clear_in;
    assign hit = rd_valid && (rd_tag == fetch_pc_in[31:INDEX_BITS+2]);

    icache_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .clr_all_in   (clr_all),
        .rd_idx_in    (fetch_pc_in[INDEX_BITS+1:2]),
        .rd_valid_out (rd_valid),
        .rd_tag_out   (rd_tag),
        .rd_data_out  (rd_data),
        .we_in        (we),
        .wr_idx_in    (addr_q[INDEX_BITS+1:2]),
        .wr_tag_in    (addr_q[31:INDEX_BITS+2]),
        .wr_data_in   (value_load)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        inst_vld_d   = inst_vld_q;
        inst_d       = inst_q;
        no_install_d = no_install_q;
        we           = 1'b0;
        clr_all      = 1'b0;
        if (rdy_in) begin
            inst_vld_d = 1'b0;
            clr_all    = clear_in;
            // A clear during a refill must also keep that refill out of the array.
            if (clear_in && state_q != ST_IDLE) begin
                no_install_d = 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (fetch_valid_in && fetch_ready_out) begin
                        if (hit) begin
                            inst_vld_d = 1'b1;
                            inst_d     = rd_data;
                        end else begin
                            req_d        = 1'b1;
                            addr_d       = {fetch_pc_in[31:2], 2'b00};
                            no_install_d = 1'b0;
                            state_d      = ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (icache_received) begin
                        req_d   = 1'b0;
                        state_d = ST_WAIT;
                        if (icache_task_out) begin
                            we         = !clear_in && !no_install_q;
                            inst_vld_d = 1'b1;
                            inst_d     = value_load;
                            state_d    = ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (icache_task_out) begin
                        we         = !clear_in && !no_install_q;
                        inst_vld_d = 1'b1;
                        inst_d     = value_load;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            addr_q       <= '0;
            inst_vld_q   <= 1'b0;
            inst_q       <= '0;
            no_install_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            inst_vld_q   <= inst_vld_d;
            inst_q       <= inst_d;
            no_install_q <= no_install_d;
        end
    end

    assign inst_valid_out    = inst_vld_q;
    assign inst_out          = inst_q;
    assign icache_in         = req_q;
    assign icache_address_in = addr_q;

endmodule
